// File: rtl/pixel_sum_accum.sv
// Per-image brightness accumulator: sums NUM_PIXELS unsigned 8-bit pixels after a start pulse
// and presents the 22-bit total with its image tag until the downstream sorter consumes it.

module cla24 (
  input  logic [23:0] i_a,
  input  logic [23:0] i_b,
  input  logic        i_cin,
  output logic [23:0] o_sum,
  output logic        o_cout
);

  logic [23:0] w_p;
  logic [23:0] w_g;
  logic [23:0] w_c;
  logic [5:0]  w_gp;
  logic [5:0]  w_gg;
  logic [6:0]  w_gc;

  // Flat sum-of-products carry into nibble group k from the group generate/propagate terms.
  function automatic logic f_group_carry(input logic [5:0] gp, input logic [5:0] gg,
                                         input logic cin, input int k);
    logic c;
    logic pr;
    c  = 1'b0;
    pr = 1'b1;
    for (int j = k - 1; j >= 0; j--) begin
      c  = c | (gg[j] & pr);
      pr = pr & gp[j];
    end
    return c | (pr & cin);
  endfunction

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;
  assign w_gc[0] = i_cin;

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_group
      assign w_gp[gi] = &w_p[4*gi +: 4];
      assign w_gg[gi] = w_g[4*gi+3]
                      | (w_p[4*gi+3] & w_g[4*gi+2])
                      | (w_p[4*gi+3] & w_p[4*gi+2] & w_g[4*gi+1])
                      | (w_p[4*gi+3] & w_p[4*gi+2] & w_p[4*gi+1] & w_g[4*gi]);

      assign w_c[4*gi]   = w_gc[gi];
      assign w_c[4*gi+1] = w_g[4*gi] | (w_p[4*gi] & w_gc[gi]);
      assign w_c[4*gi+2] = w_g[4*gi+1]
                         | (w_p[4*gi+1] & w_g[4*gi])
                         | (w_p[4*gi+1] & w_p[4*gi] & w_gc[gi]);
      assign w_c[4*gi+3] = w_g[4*gi+2]
                         | (w_p[4*gi+2] & w_g[4*gi+1])
                         | (w_p[4*gi+2] & w_p[4*gi+1] & w_g[4*gi])
                         | (w_p[4*gi+2] & w_p[4*gi+1] & w_p[4*gi] & w_gc[gi]);

      assign w_gc[gi+1] = f_group_carry(w_gp, w_gg, i_cin, gi + 1);
    end
  endgenerate

  assign o_sum  = w_p ^ w_c;
  assign o_cout = w_gc[6];

endmodule

module pixel_sum_accum #(
  parameter int NUM_PIXELS = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  img_id,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        pix_ready,
  output logic        sum_valid,
  input  logic        sum_ready,
  output logic [21:0] sum_out,
  output logic [3:0]  id_out,
  output logic        busy
);

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_ACCUM = 2'd1;
  localparam logic [1:0]  ST_DONE  = 2'd2;
  localparam logic [14:0] LAST_IDX = 15'(NUM_PIXELS - 1);

  logic [1:0]  r_state;
  logic [21:0] r_acc;
  logic [14:0] r_cnt;
  logic [3:0]  r_id;

  logic [23:0] w_sum;
  logic        w_cout;
  logic        w_accept;
  logic        w_unused;

  cla24 u_add (
    .i_a    ({2'b00, r_acc}),
    .i_b    ({16'h0000, pix_data}),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // The sum never exceeds 22 bits, so the adder's top bits carry no information.
  assign w_unused = ^{w_cout, w_sum[23:22]};

  assign w_accept  = pix_valid && (r_state == ST_ACCUM);
  assign pix_ready = (r_state == ST_ACCUM);
  assign sum_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign sum_out   = r_acc;
  assign id_out    = r_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_id    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_id    <= img_id;
            r_state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (w_accept) begin
            r_acc <= w_sum[21:0];
            r_cnt <= r_cnt + 15'd1;
            if (r_cnt == LAST_IDX) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (sum_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pixel_sum_accum.md
PIXEL_SUM_ACCUM -- requirements
Module: pixel_sum_accum

Interface
REQ-001 Parameter: NUM_PIXELS, default 16384, number of pixels per image (legal range 1..16384).
REQ-002 Port: clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: start  input  1  single-cycle pulse that begins accumulation of one image.
REQ-005 Port: img_id  input  4  image tag, sampled on an accepted start.
REQ-006 Port: pix_valid  input  1  pix_data is valid this cycle.
REQ-007 Port: pix_data  input  8  unsigned grayscale pixel.
REQ-008 Port: pix_ready  output  1  block accepts a pixel this cycle.
REQ-009 Port: sum_valid  output  1  sum_out and id_out are valid.
REQ-010 Port: sum_ready  input  1  downstream sorter consumes the result.
REQ-011 Port: sum_out  output  22  unsigned brightness sum of the image.
REQ-012 Port: id_out  output  4  tag of the image whose sum is presented.
REQ-013 Port: busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACCUM, DONE.
REQ-015 IDLE: start=1 SHALL clear the accumulator and the pixel counter, latch img_id, and enter ACCUM next cycle.
REQ-016 start SHALL be ignored in ACCUM and DONE; img_id SHALL be sampled only on an accepted start.
REQ-017 pix_ready SHALL be 1 in ACCUM and 0 in IDLE and DONE; a pixel is accepted when pix_valid and pix_ready are both 1.
REQ-018 On acceptance, the accumulator SHALL become accumulator + {14'b0, pix_data}, computed by an instance of CLA24 with Cin tied to 0.
REQ-019 Pixels presented outside ACCUM SHALL be ignored; stalls (pix_valid=0) SHALL leave accumulator and counter unchanged.
REQ-020 The pixel counter SHALL be 15 bits wide and SHALL increment once per accepted pixel.
REQ-021 Acceptance of pixel number NUM_PIXELS (counter == NUM_PIXELS-1) SHALL move the FSM to DONE on the next edge, with the final sum included.
REQ-022 No overflow handling is required: 16384 x 255 = 4177920 < 2^22.
REQ-023 DONE: sum_valid SHALL be 1, with sum_out and id_out held stable until the cycle in which sum_ready=1.
REQ-024 The sum_valid/sum_ready handshake SHALL return the FSM to IDLE; sum_valid SHALL be 0 on the following cycle.
REQ-025 sum_ready SHALL be ignored outside DONE.
REQ-026 Latency: sum_valid SHALL rise exactly 1 cycle after the last pixel is accepted.
REQ-027 Throughput: one pixel per cycle with no bubbles.
REQ-028 A start that coincides with the DONE handshake SHALL be ignored; the next start is honoured in IDLE.
REQ-029 sum_out and id_out SHALL retain their last values in IDLE until the next accepted start clears the accumulator.

Reset
REQ-030 rst=1 SHALL force IDLE, accumulator=0, counter=0, latched id=0, pix_ready=0, sum_valid=0, busy=0, sum_out=0 and id_out=0 on the next edge.
REQ-031 rst SHALL override start, pix_valid and sum_ready in the same cycle, including mid-ACCUM and in DONE; the partial sum SHALL be discarded.

Verification
REQ-032 NUM_PIXELS=4, start with img_id=5, pixels 10,20,30,40 on consecutive cycles -> sum_valid 1 cycle after the 4th pixel, sum_out=100, id_out=5.
REQ-033 Default NUM_PIXELS, 16384 pixels of 255 with random pix_valid gaps -> sum_out=4177920 with no wrap; pix_ready=1 throughout ACCUM.
REQ-034 DONE with sum_ready held 0 for 10 cycles, then pulsed -> sum_out and id_out stable all 10 cycles; IDLE and sum_valid=0 the next cycle.
REQ-035 start pulsed during ACCUM with img_id=9 -> ignored; id_out keeps the original tag and the sum is unaffected.
REQ-036 rst asserted after 2 of 4 pixels, then new start and pixels 1,1,1,1 -> sum_out=4 (no residue from the aborted image).
REQ-037 pix_valid=1 while IDLE or DONE -> pix_ready=0 and the accumulator is unchanged.
